// File: rtl/afifo_pkg.sv
// afifo_pkg: shared constants and pointer helpers for the asynchronous FIFO
package afifo_pkg;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int SYNC_STAGES_DEF = 2;
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction
  function automatic logic [31:0] bin_to_gray(input logic [31:0] b, input int w);
    return (b ^ (b >> 1)) & ((32'd1 << w) - 32'd1);
  endfunction
  function automatic logic [31:0] gray_to_bin(input logic [31:0] g, input int w);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b ^= g >> i;
    return b & ((32'd1 << w) - 32'd1);
  endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: W-bit, STAGES-deep clock-domain-crossing flop chain with async reset to 0
module sync_ff #(
  parameter int W = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s [STAGES];
  // shift the crossing value through the chain; only the last stage is consumed
  always_ff @(posedge clk or posedge rst)
    if (rst) s <= '{default: '0};
    else begin
      s[0] <= d;
      for (int i = 1; i < STAGES; i++) s[i] <= s[i-1];
    end
  assign q = s[STAGES-1];
endmodule

// File: rtl/afifo_rd_ctrl.sv
// afifo_rd_ctrl: async FIFO read-side pointer/empty control; AFIFO_RD_LEVEL_EN adds level_o
module afifo_rd_ctrl
  import afifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  localparam int PTR_W = ptr_width(ADDR_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [PTR_W-1:0]      wr_ptr_gray_i,
  input  logic                  rd_ready_i,
  output logic                  rd_valid_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [PTR_W-1:0]      rd_ptr_gray_o,
  output logic [PTR_W-1:0]      level_o
);
  logic [PTR_W-1:0] wr_gray_s, rd_ptr_bin, rd_bin_nxt, rd_gray_nxt;
  logic pop;
  sync_ff #(.W(PTR_W), .STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(clk_i),
    .rst(rst_i),
    .d(wr_ptr_gray_i),
    .q(wr_gray_s)
  );
  assign rd_valid_o = ~empty_o;
  assign pop = rd_valid_o & rd_ready_i;
  assign rd_bin_nxt = rd_ptr_bin + PTR_W'(pop);
  assign rd_gray_nxt = PTR_W'(bin_to_gray(32'(rd_bin_nxt), PTR_W));
  // advance the read pointer; empty compares the post-pop Gray pointer with the newest synced write pointer
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rd_ptr_bin <= '0;
      rd_ptr_gray_o <= '0;
      rd_addr_o <= '0;
      empty_o <= 1'b1;
    end else begin
      rd_ptr_bin <= rd_bin_nxt;
      rd_ptr_gray_o <= rd_gray_nxt;
      rd_addr_o <= rd_bin_nxt[ADDR_WIDTH-1:0];
      empty_o <= rd_gray_nxt == wr_gray_s;
    end
`ifdef AFIFO_RD_LEVEL_EN
  logic [PTR_W-1:0] wr_bin_s;
  assign wr_bin_s = PTR_W'(gray_to_bin(32'(wr_gray_s), PTR_W));
  // occupancy as seen after this cycle's pop, wrapping modulo the pointer range
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) level_o <= '0;
    else level_o <= wr_bin_s - rd_bin_nxt;
`else
  assign level_o = '0;
`endif
endmodule

// File: doc/afifo_rd_ctrl.md
Name: afifo_rd_ctrl

Overview:
- Read-domain control block of the team's asynchronous FIFO. Sits directly downstream of the write-domain Gray pointer and consumes it.
- Synchronizes the incoming Gray write pointer and converts it to binary.
- Maintains the read pointer in binary and Gray, produces the RAM read address, and generates empty/valid.
- Returns its own Gray read pointer for synchronization into the write domain.

Parameters:
- ADDR_WIDTH, 4, FIFO RAM address width; depth = 2**ADDR_WIDTH; pointer width PTR_W = ADDR_WIDTH+1.
- SYNC_STAGES, 2, flop stages in the write-pointer synchronizer; legal range 2..4.

Ports:
- clk_i  in  1  read-domain clock.
- rst_i  in  1  reset; asynchronous assert, active-high, read domain.
- wr_ptr_gray_i  in  PTR_W  Gray write pointer, launched from write-domain flops.
- rd_ready_i  in  1  consumer accepts the current word.
- rd_valid_o  out  1  word available at rd_addr_o; equals ~empty_o.
- empty_o  out  1  registered empty flag.
- rd_addr_o  out  ADDR_WIDTH  RAM read address of the head word.
- rd_ptr_gray_o  out  PTR_W  registered Gray read pointer, sent to the write domain.
- level_o  out  PTR_W  occupancy seen by the read side (optional feature only).

Behaviour:
- Reset, asynchronous and immediate with no clock edge required:
  - synchronizer flops = 0, rd_ptr_bin = 0, rd_ptr_gray_o = 0, rd_addr_o = 0.
  - empty_o = 1, rd_valid_o = 0, level_o = 0.
- Synchronizer: wr_ptr_gray_i passes through SYNC_STAGES flops, giving wr_gray_s. wr_bin_s = Gray-to-binary of wr_gray_s (combinational XOR prefix).
- Pop: pop = rd_valid_o & rd_ready_i. rd_ready_i while empty is ignored; no state change.
- Next pointer: rd_bin_nxt = rd_ptr_bin + pop, modulo 2**PTR_W. The wrap from 2**PTR_W-1 to 0 toggles the MSB. rd_gray_nxt = rd_bin_nxt ^ (rd_bin_nxt >> 1).
- Registered updates on every clk_i edge:
  - rd_ptr_bin <= rd_bin_nxt.
  - rd_ptr_gray_o <= rd_gray_nxt.
  - rd_addr_o <= rd_bin_nxt[ADDR_WIDTH-1:0].
  - empty_o <= (rd_gray_nxt == wr_gray_s).
- Latency:
  - A write-pointer change on wr_ptr_gray_i deasserts empty_o SYNC_STAGES+1 clk_i edges later.
  - A pop updates rd_addr_o and rd_ptr_gray_o on the next edge.
  - Back-to-back pops are sustained at one per cycle while data remains.
- Simultaneous pop and write-pointer advance: empty_o is computed from the post-pop pointer against the newest wr_gray_s; no word is skipped or duplicated.
- Last word popped (pointer equal after pop): empty_o = 1 next edge. rd_ready_i held high then has no effect.
- rd_ptr_gray_o changes at most one bit per cycle and is driven directly from a flop, with no logic after it.
- Full condition (wr_bin_s - rd_ptr_bin == 2**ADDR_WIDTH) is legal and handled. Differences above the depth cannot occur with a correct writer and are not checked.

Optional Feature:
- Macro: AFIFO_RD_LEVEL_EN.
- Defined: level_o <= (wr_bin_s - rd_bin_nxt) mod 2**PTR_W, registered, range 0..2**ADDR_WIDTH, reset 0.
- Undefined: level_o tied to 0, and the subtractor is not built.

Decomposition:
- Package afifo_pkg holds:
  - function ptr_width(addr_width) returning addr_width+1.
  - bin_to_gray and gray_to_bin functions, parameterised by width.
  - default constants for ADDR_WIDTH and SYNC_STAGES.
- One sub-module: sync_ff (width- and stage-parameterised flop chain, async active-high reset to 0). The write-domain control block reuses it.

Test Plan (ADDR_WIDTH=4, SYNC_STAGES=2):
- Reset: assert rst_i between clock edges -> immediately empty_o=1, rd_valid_o=0, rd_addr_o=0, rd_ptr_gray_o=5'b00000, level_o=0.
- One write: wr_ptr_gray_i 00000->00001 at edge 0, rd_ready_i=0 -> rd_valid_o=1 after edge 3, rd_addr_o=0, level_o=1. Then rd_ready_i=1 for one cycle -> rd_addr_o=1, rd_ptr_gray_o=00001, empty_o=1.
- Full: wr_ptr_gray_i=11000 (bin 16) -> level_o=16. Sixteen consecutive pops -> rd_ptr_gray_o=11000, empty_o=1 after the 16th, no extra pop.
- Wrap: both sides advance through bin 31->0 (Gray 10000->00000) -> rd_addr_o sequence 14,15,0,1, empty correct throughout, pointer MSB toggles.
- Concurrent: pop every cycle while wr pointer advances by one each cycle -> rd_valid_o stays 1, no bubble, popped addresses strictly sequential.
- Reset mid-stream at level_o=5 with rd_ready_i=1 -> all outputs at reset values asynchronously. After release, the synchronized write pointer is re-acquired from 0.
